// File: rtl/tdl_delay_ctrl_if.sv
// Control bus of the tapped-delay-line loop: phase-detector votes and enable in,
// decoded tap selects and status out.
interface tdl_delay_ctrl_if;
   logic       en;
   logic       pd_up;
   logic       pd_dn;
   logic [7:0] lambda;
   logic [7:0] lambda_bar;
   logic [2:0] sel;
   logic       locked;
   logic       at_min;
   logic       at_max;

   modport master (
      output en, pd_up, pd_dn,
      input  lambda, lambda_bar, sel, locked, at_min, at_max
   );

   modport slave (
      input  en, pd_up, pd_dn,
      output lambda, lambda_bar, sel, locked, at_min, at_max
   );
endinterface

// File: rtl/tdl_delay_ctrl.sv
// Vote-accumulating tap controller for the 8-tap delay line; decoded outputs registered,
// new code two edges after the last window sample. No backpressure: pd ignored outside ACC.
module tdl_delay_ctrl #(
   parameter int ACC_LEN  = 16,
   parameter int THRESH   = 4,
   parameter int SETTLE   = 8,
   parameter int LOCK_CNT = 4,
   parameter int INIT_SEL = 0
) (
   input logic            clk,
   input logic            rst,
   tdl_delay_ctrl_if.slave bus
);

   localparam int ACC_W = $clog2(ACC_LEN) + 2;
   localparam int CNT_W = $clog2(ACC_LEN);
   localparam int SET_W = $clog2(SETTLE + 1);
   localparam int LCK_W = $clog2(LOCK_CNT + 1);

   localparam logic signed [ACC_W-1:0] THR_P       = ACC_W'(THRESH);
   localparam logic signed [ACC_W-1:0] THR_N       = -THR_P;
   localparam logic [CNT_W-1:0]        CNT_LAST    = CNT_W'(ACC_LEN - 1);
   localparam logic [SET_W-1:0]        SETTLE_LAST = SET_W'(SETTLE - 1);
   localparam logic [LCK_W-1:0]        LOCK_MAX    = LCK_W'(LOCK_CNT);
   localparam logic [2:0]              INIT_P      = 3'(INIT_SEL);
   localparam logic [7:0]              INIT_LAMBDA = 8'd1 << INIT_P;
   localparam logic [7:0]              INIT_BAR    = (INIT_LAMBDA - 8'd1) & 8'h7F;

   typedef enum logic [1:0] {S_IDLE, S_ACC, S_STEP, S_SETTLE} state_t;

   state_t                  state_q, state_d;
   logic signed [ACC_W-1:0] acc_q, acc_d;
   logic signed [ACC_W-1:0] vote;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [SET_W-1:0]        settle_q, settle_d;
   logic [LCK_W-1:0]        lock_q, lock_d;
   logic                    locked_q, locked_d;
   logic [2:0]              sel_q, sel_d;
   logic [7:0]              lambda_q, lambda_d;
   logic [7:0]              lambda_bar_q, lambda_bar_d;
   logic                    at_min_q, at_max_q;

   always_comb begin
      vote = '0;
      if (bus.pd_up && !bus.pd_dn) begin
         vote = ACC_W'(1);
      end else if (bus.pd_dn && !bus.pd_up) begin
         vote = '1;
      end
   end

   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      settle_d = settle_q;
      lock_d   = lock_q;
      locked_d = locked_q;
      sel_d    = sel_q;
      if (!bus.en) begin
         // Disable wins in every state; the tap code is deliberately kept.
         state_d  = S_IDLE;
         acc_d    = '0;
         cnt_d    = '0;
         settle_d = '0;
         lock_d   = '0;
         locked_d = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               state_d = S_ACC;
            end
            S_ACC: begin
               acc_d = acc_q + vote;
               if (cnt_q == CNT_LAST) begin
                  cnt_d   = '0;
                  state_d = S_STEP;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            S_STEP: begin
               acc_d   = '0;
               cnt_d   = '0;
               state_d = S_ACC;
               if (acc_q >= THR_P) begin
                  lock_d   = '0;
                  locked_d = 1'b0;
                  if (sel_q != 3'd7) begin
                     sel_d   = sel_q + 3'd1;
                     state_d = S_SETTLE;
                  end
               end else if (acc_q <= THR_N) begin
                  lock_d   = '0;
                  locked_d = 1'b0;
                  if (sel_q != 3'd0) begin
                     sel_d   = sel_q - 3'd1;
                     state_d = S_SETTLE;
                  end
               end else begin
                  if (lock_q != LOCK_MAX) begin
                     lock_d = lock_q + LCK_W'(1);
                  end
                  locked_d = (lock_d == LOCK_MAX);
               end
            end
            S_SETTLE: begin
               if (settle_q == SETTLE_LAST) begin
                  settle_d = '0;
                  state_d  = S_ACC;
               end else begin
                  settle_d = settle_q + SET_W'(1);
               end
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   // Decode from the next index so every output bus flips on the same edge.
   always_comb begin
      lambda_d     = 8'd1 << sel_d;
      lambda_bar_d = (lambda_d - 8'd1) & 8'h7F;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         acc_q        <= '0;
         cnt_q        <= '0;
         settle_q     <= '0;
         lock_q       <= '0;
         locked_q     <= 1'b0;
         sel_q        <= INIT_P;
         lambda_q     <= INIT_LAMBDA;
         lambda_bar_q <= INIT_BAR;
         at_min_q     <= (INIT_P == 3'd0);
         at_max_q     <= (INIT_P == 3'd7);
      end else begin
         state_q      <= state_d;
         acc_q        <= acc_d;
         cnt_q        <= cnt_d;
         settle_q     <= settle_d;
         lock_q       <= lock_d;
         locked_q     <= locked_d;
         sel_q        <= sel_d;
         lambda_q     <= lambda_d;
         lambda_bar_q <= lambda_bar_d;
         at_min_q     <= (sel_d == 3'd0);
         at_max_q     <= (sel_d == 3'd7);
      end
   end

   assign bus.sel        = sel_q;
   assign bus.lambda     = lambda_q;
   assign bus.lambda_bar = lambda_bar_q;
   assign bus.locked     = locked_q;
   assign bus.at_min     = at_min_q;
   assign bus.at_max     = at_max_q;

endmodule

// File: tb/tb_tdl_delay_ctrl.sv
// Bench for tdl_delay_ctrl: per-window expectations queued at stimulus time,
// popped and compared on the edge that ends STEP.
module tb_tdl_delay_ctrl;
   localparam int ACC_LEN  = 16;
   localparam int THRESH   = 4;
   localparam int SETTLE   = 8;
   localparam int LOCK_CNT = 4;

   typedef struct packed {
      logic [2:0] sel;
      logic       locked;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];
   logic [2:0] m_sel;
   int   m_lock;
   logic m_locked;

   tdl_delay_ctrl_if bus();

   tdl_delay_ctrl #(
      .ACC_LEN(ACC_LEN), .THRESH(THRESH), .SETTLE(SETTLE),
      .LOCK_CNT(LOCK_CNT), .INIT_SEL(0)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] onehot(input logic [2:0] s);
      logic [7:0] r;
      for (int k = 0; k < 8; k++) r[k] = (k == int'(s));
      return r;
   endfunction

   function automatic logic [7:0] therm(input logic [2:0] s);
      logic [7:0] r;
      for (int k = 0; k < 8; k++) r[k] = (k < int'(s)) && (k != 7);
      return r;
   endfunction

   // Drives one 16-sample window starting in ACC; pd_up is held high in the
   // ignored STEP/SETTLE cycles so any leak into the accumulator shows up later.
   task automatic run_window(input logic [15:0] up, input logic [15:0] dn, input string name);
      int         acc;
      logic [2:0] old_sel;
      bit         stepped;
      exp_t       e;
      acc     = 0;
      stepped = 0;
      old_sel = m_sel;
      for (int i = 0; i < ACC_LEN; i++) begin
         if (up[i] && !dn[i]) acc++;
         else if (dn[i] && !up[i]) acc--;
      end
      if (acc >= THRESH) begin
         if (m_sel != 3'd7) begin m_sel = m_sel + 3'd1; stepped = 1; end
         m_lock = 0; m_locked = 1'b0;
      end else if (acc <= -THRESH) begin
         if (m_sel != 3'd0) begin m_sel = m_sel - 3'd1; stepped = 1; end
         m_lock = 0; m_locked = 1'b0;
      end else begin
         if (m_lock < LOCK_CNT) m_lock++;
         if (m_lock == LOCK_CNT) m_locked = 1'b1;
      end
      e.sel = m_sel;
      e.locked = m_locked;
      sb.push_back(e);

      for (int i = 0; i < ACC_LEN; i++) begin
         bus.pd_up = up[i];
         bus.pd_dn = dn[i];
         tick();
      end
      bus.pd_up = 1'b1;
      bus.pd_dn = 1'b0;
      checks++;
      if (bus.sel !== old_sel) begin
         errors++;
         $display("FAIL %s early_change: sel=%0d required=%0d", name, bus.sel, old_sel);
      end
      tick();
      if (sb.size() == 0) begin
         errors++;
         $display("FAIL %s scoreboard_empty", name);
      end else begin
         e = sb.pop_front();
         checks++;
         if (bus.sel !== e.sel) begin
            errors++;
            $display("FAIL %s sel: got=%0d required=%0d", name, bus.sel, e.sel);
         end
         checks++;
         if (bus.lambda !== onehot(e.sel)) begin
            errors++;
            $display("FAIL %s lambda: got=%h required=%h", name, bus.lambda, onehot(e.sel));
         end
         checks++;
         if (bus.lambda_bar !== therm(e.sel)) begin
            errors++;
            $display("FAIL %s lambda_bar: got=%h required=%h", name, bus.lambda_bar, therm(e.sel));
         end
         checks++;
         if (bus.locked !== e.locked) begin
            errors++;
            $display("FAIL %s locked: got=%b required=%b", name, bus.locked, e.locked);
         end
         checks++;
         if ({bus.at_min, bus.at_max} !== {e.sel == 3'd0, e.sel == 3'd7}) begin
            errors++;
            $display("FAIL %s bounds: got=%b%b required=%b%b", name, bus.at_min, bus.at_max,
                     e.sel == 3'd0, e.sel == 3'd7);
         end
      end
      if (stepped) begin
         repeat (SETTLE) tick();
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.en = 1'b0;
      bus.pd_up = 1'b0;
      bus.pd_dn = 1'b0;
      m_sel = 3'd0; m_lock = 0; m_locked = 1'b0;
      #2;
      checks++;
      if ({bus.sel, bus.lambda, bus.lambda_bar, bus.at_min, bus.at_max, bus.locked}
          !== {3'd0, 8'h01, 8'h00, 1'b1, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL reset_values: sel=%0d lambda=%h bar=%h min=%b max=%b locked=%b required 0/01/00/1/0/0",
                  bus.sel, bus.lambda, bus.lambda_bar, bus.at_min, bus.at_max, bus.locked);
      end
      @(negedge clk);
      rst = 1'b0;
      tick();
      tick();
      checks++;
      if (bus.sel !== 3'd0 || bus.lambda !== 8'h01) begin
         errors++;
         $display("FAIL idle_hold: sel=%0d lambda=%h required 0/01", bus.sel, bus.lambda);
      end
   endtask

   task automatic test_single_up();
      bus.en = 1'b1;
      tick();
      run_window(16'hFFFF, 16'h0000, "single_up");
      checks++;
      if (bus.lambda !== 8'h02 || bus.lambda_bar !== 8'h01) begin
         errors++;
         $display("FAIL single_up_code: lambda=%h bar=%h required 02/01", bus.lambda, bus.lambda_bar);
      end
      run_window(16'h0000, 16'h0000, "after_settle");
   endtask

   task automatic test_saturation();
      for (int w = 0; w < 6; w++) run_window(16'hFFFF, 16'h0000, "climb");
      checks++;
      if (bus.lambda !== 8'h80 || bus.lambda_bar !== 8'h7F || bus.at_max !== 1'b1) begin
         errors++;
         $display("FAIL sat_code: lambda=%h bar=%h max=%b required 80/7F/1",
                  bus.lambda, bus.lambda_bar, bus.at_max);
      end
      run_window(16'hFFFF, 16'h0000, "sat_up");
      for (int w = 0; w < 4; w++) run_window(16'h0000, 16'hFFFF, "descend");
   endtask

   task automatic test_lock();
      for (int w = 0; w < 4; w++) begin
         run_window(16'h5555, 16'hAAAA, "lock_alt");
         if (w == 2) begin
            checks++;
            if (bus.locked !== 1'b0) begin
               errors++;
               $display("FAIL lock_early: locked=%b required=0", bus.locked);
            end
         end
      end
      checks++;
      if (bus.locked !== 1'b1) begin
         errors++;
         $display("FAIL lock_rise: locked=%b required=1", bus.locked);
      end
      run_window(16'h0000, 16'hFFFF, "lock_break");
      checks++;
      if (bus.sel !== 3'd2 || bus.lambda !== 8'h04 || bus.lambda_bar !== 8'h03 || bus.locked !== 1'b0) begin
         errors++;
         $display("FAIL lock_break_code: sel=%0d lambda=%h bar=%h locked=%b required 2/04/03/0",
                  bus.sel, bus.lambda, bus.lambda_bar, bus.locked);
      end
   endtask

   task automatic test_threshold();
      run_window(16'h03FF, 16'hFC00, "thr_plus4");
      run_window(16'h01FF, 16'hFE00, "thr_plus2");
      run_window(16'hFFFF, 16'hFFFF, "tie_both");
      run_window(16'h003F, 16'hFFC0, "thr_minus4");
      for (int w = 0; w < 4; w++) run_window(16'h5555, 16'hAAAA, "relock");
   endtask

   task automatic test_enable_drop();
      for (int i = 0; i < 9; i++) begin
         bus.pd_up = 1'b0;
         bus.pd_dn = 1'b1;
         tick();
      end
      bus.en = 1'b0;
      tick();
      m_lock = 0;
      m_locked = 1'b0;
      checks++;
      if (bus.locked !== 1'b0 || bus.sel !== m_sel) begin
         errors++;
         $display("FAIL en_drop: locked=%b sel=%0d required 0/%0d", bus.locked, bus.sel, m_sel);
      end
      repeat (3) tick();
      checks++;
      if (bus.sel !== m_sel || bus.lambda !== onehot(m_sel)) begin
         errors++;
         $display("FAIL en_hold: sel=%0d lambda=%h required %0d/%h", bus.sel, bus.lambda,
                  m_sel, onehot(m_sel));
      end
      bus.en = 1'b1;
      tick();
      run_window(16'h03FF, 16'hFC00, "reenable");
      run_window(16'h5555, 16'hAAAA, "reenable_lock");
   endtask

   task automatic test_async_reset();
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      checks++;
      if ({bus.sel, bus.lambda, bus.lambda_bar, bus.at_min, bus.at_max, bus.locked}
          !== {3'd0, 8'h01, 8'h00, 1'b1, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL async_reset: sel=%0d lambda=%h bar=%h min=%b max=%b locked=%b required 0/01/00/1/0/0",
                  bus.sel, bus.lambda, bus.lambda_bar, bus.at_min, bus.at_max, bus.locked);
      end
      bus.en = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      tick();
   endtask

   initial begin
      test_reset();
      test_single_up();
      test_saturation();
      test_lock();
      test_threshold();
      test_enable_drop();
      test_async_reset();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_leftover: entries=%0d required=0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
